// File: rtl/id_operand_stage_pkg.sv
// Shared decode constants, hold-FSM state type and forwarding-entry width helper
// for the ID operand stage.
package id_operand_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  typedef enum logic {
    HOLD_RUN  = 1'b0,
    HOLD_HELD = 1'b1
  } hold_state_e;

  // Width of one {we, waddr, wdata} forwarding entry.
  function automatic int fwd_ent_wd(input int ra_w, input int data_w);
    return 1 + ra_w + data_w;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Priority forwarding mux for one source operand: lowest-index matching writer
// wins, else regfile data; register 0 always reads as zero.
module id_fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int NUM_FWD = 3,
  parameter int RA_W    = 5,
  parameter int DATA_W  = 32
) (
  input  logic [NUM_FWD*(1+RA_W+DATA_W)-1:0] fwd_bus,
  input  logic [RA_W-1:0]                    raddr,
  input  logic [DATA_W-1:0]                  rf_rdata,
  output logic [DATA_W-1:0]                  data
);

  localparam int ENT_W = fwd_ent_wd(RA_W, DATA_W);

  logic [ENT_W-1:0] ent;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned; a missing default would infer a latch.
  always_comb begin
    data = rf_rdata;
    ent  = '0;
    // Walk from oldest to youngest so the youngest match overwrites last.
    for (int s = NUM_FWD - 1; s >= 0; s--) begin
      ent = fwd_bus[s*ENT_W +: ENT_W];
      if (ent[ENT_W-1] && (ent[DATA_W +: RA_W] == raddr)) begin
        data = ent[DATA_W-1:0];
      end
    end
    if (raddr == '0) begin
      data = '0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand unit: IF->ID register, stall hold buffer, forwarding,
// load-use detection and ID-stage branch resolve. Optional counters: ID_PERF_CNT_EN.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int RA_W    = 5,
  parameter int NUM_FWD = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall_id,
  input  logic                               stall_ex,
  input  logic                               if_valid,
  input  logic [PC_W-1:0]                    if_pc,
  input  logic [31:0]                        inst_rdata,
  input  logic [NUM_FWD*(1+RA_W+DATA_W)-1:0] fwd_bus,
  input  logic                               ex_is_load,
  output logic [RA_W-1:0]                    rf_raddr1,
  output logic [RA_W-1:0]                    rf_raddr2,
  input  logic [DATA_W-1:0]                  rf_rdata1,
  input  logic [DATA_W-1:0]                  rf_rdata2,
  output logic                               id_valid,
  output logic [PC_W-1:0]                    id_pc,
  output logic [31:0]                        id_inst,
  output logic [DATA_W-1:0]                  src1,
  output logic [DATA_W-1:0]                  src2,
  output logic                               stallreq,
  output logic                               br_taken,
  output logic [PC_W-1:0]                    br_target,
  output logic [31:0]                        perf_lu_cnt,
  output logic [31:0]                        perf_br_cnt
);

  localparam int ENT_W = fwd_ent_wd(RA_W, DATA_W);

  hold_state_e state_q, state_d;
  logic [31:0] hold_reg;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (stall_id && !stall_ex) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
    end else if (!stall_id) begin
      id_valid <= if_valid;
      id_pc    <= if_pc;
    end
  end

  // The SRAM re-reads a new address while ID is stalled, so the word seen on
  // the first stalled edge is parked until the stall lifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HOLD_RUN;
      hold_reg <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == HOLD_RUN && stall_id) begin
        hold_reg <= inst_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD_RUN:  if (stall_id)  state_d = HOLD_HELD;
      HOLD_HELD: if (!stall_id) state_d = HOLD_RUN;
      default:   state_d = HOLD_RUN;
    endcase
  end

  assign id_inst = !id_valid ? '0 : ((state_q == HOLD_HELD) ? hold_reg : inst_rdata);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [25:0] index;

  assign op    = id_inst[31:26];
  assign rs    = id_inst[25:21];
  assign rt    = id_inst[20:16];
  assign imm   = id_inst[15:0];
  assign funct = id_inst[5:0];
  assign index = id_inst[25:0];

  assign rf_raddr1 = RA_W'(rs);
  assign rf_raddr2 = RA_W'(rt);

  id_fwd_mux #(.NUM_FWD(NUM_FWD), .RA_W(RA_W), .DATA_W(DATA_W)) u_fwd_rs (
    .fwd_bus  (fwd_bus),
    .raddr    (rf_raddr1),
    .rf_rdata (rf_rdata1),
    .data     (src1)
  );

  id_fwd_mux #(.NUM_FWD(NUM_FWD), .RA_W(RA_W), .DATA_W(DATA_W)) u_fwd_rt (
    .fwd_bus  (fwd_bus),
    .raddr    (rf_raddr2),
    .rf_rdata (rf_rdata2),
    .data     (src2)
  );

  logic            use_rs, use_rt;
  logic            ex_we;
  logic [RA_W-1:0] ex_waddr;

  assign use_rs   = !(op == OP_J || op == OP_JAL || op == OP_LUI);
  assign use_rt   = (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) ||
                    (op[5:3] == 3'b101);
  assign ex_we    = fwd_bus[ENT_W-1];
  assign ex_waddr = fwd_bus[DATA_W +: RA_W];

  assign stallreq = id_valid && ex_is_load && ex_we && (ex_waddr != '0) &&
                    ((use_rs && ex_waddr == rf_raddr1) ||
                     (use_rt && ex_waddr == rf_raddr2));

  logic [PC_W-1:0] pc_plus4, br_off_target, target;
  logic            src1_neg, src1_zero, cond_taken, is_jump;

  assign pc_plus4      = id_pc + PC_W'(4);
  assign br_off_target = pc_plus4 + {{(PC_W-18){imm[15]}}, imm, 2'b00};
  assign src1_neg      = src1[DATA_W-1];
  assign src1_zero     = (src1 == '0);

  always_comb begin
    cond_taken = 1'b0;
    is_jump    = 1'b0;
    target     = br_off_target;
    case (op)
      OP_BEQ:  cond_taken = (src1 == src2);
      OP_BNE:  cond_taken = (src1 != src2);
      OP_BLEZ: cond_taken = src1_neg || src1_zero;
      OP_BGTZ: cond_taken = !src1_neg && !src1_zero;
      OP_REGIMM: begin
        if (rt == RT_BLTZ)      cond_taken = src1_neg;
        else if (rt == RT_BGEZ) cond_taken = !src1_neg;
      end
      OP_J, OP_JAL: begin
        is_jump = 1'b1;
        target  = {pc_plus4[PC_W-1:28], index, 2'b00};
      end
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          is_jump = 1'b1;
          target  = PC_W'(src1);
        end
      end
      default: ;
    endcase
  end

  // A branch reading a not-yet-loaded register must not redirect on stale data.
  assign br_taken  = id_valid && !stallreq && (cond_taken || is_jump);
  assign br_target = br_taken ? target : '0;

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu_cnt <= '0;
      perf_br_cnt <= '0;
    end else begin
      if (stallreq)              perf_lu_cnt <= perf_lu_cnt + 32'd1;
      if (br_taken && !stall_id) perf_br_cnt <= perf_br_cnt + 32'd1;
    end
  end
`else
  assign perf_lu_cnt = '0;
  assign perf_br_cnt = '0;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed-vector bench for id_operand_stage; expectations are hand-computed.
module tb_id_operand_stage;

  localparam int DATA_W = 32, PC_W = 32, RA_W = 5, NUM_FWD = 3;
  localparam int ENT_W = 1 + RA_W + DATA_W;

  logic                     clk = 1'b0;
  logic                     rst_n, stall_id, stall_ex, if_valid, ex_is_load;
  logic [PC_W-1:0]          if_pc;
  logic [31:0]              inst_rdata;
  logic [NUM_FWD*ENT_W-1:0] fwd_bus;
  logic [RA_W-1:0]          rf_raddr1, rf_raddr2;
  logic [DATA_W-1:0]        rf_rdata1, rf_rdata2, src1, src2;
  logic                     id_valid, stallreq, br_taken;
  logic [PC_W-1:0]          id_pc, br_target;
  logic [31:0]              id_inst, perf_lu_cnt, perf_br_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_operand_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) dut (
    .clk(clk), .rst_n(rst_n), .stall_id(stall_id), .stall_ex(stall_ex),
    .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata), .fwd_bus(fwd_bus),
    .ex_is_load(ex_is_load), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .src1(src1), .src2(src2), .stallreq(stallreq),
    .br_taken(br_taken), .br_target(br_target),
    .perf_lu_cnt(perf_lu_cnt), .perf_br_cnt(perf_br_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [ENT_W-1:0] ent(input logic we, input logic [4:0] a,
                                           input logic [31:0] d);
    return {we, a, d};
  endfunction

  // Advance one edge, then step clear of it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_id = 1'b0; stall_ex = 1'b0; if_valid = 1'b1;
    if_pc = 32'h40; inst_rdata = 32'hDEADBEEF; ex_is_load = 1'b1;
    fwd_bus = {ent(0, 0, 0), ent(0, 0, 0), ent(1, 5'd5, 32'h11)};
    rf_rdata1 = 32'h1234; rf_rdata2 = 32'h5678;
    tick(); tick();
    check("rst_valid", id_valid, 0);
    check("rst_inst", id_inst, 0);
    check("rst_src1", src1, 0);
    check("rst_br", br_taken, 0);
    check("rst_stallreq", stallreq, 0);
    check("rst_perf_lu", perf_lu_cnt, 0);

    // ADDU r3,r5,r6 with forwarding priority
    rst_n = 1'b1; ex_is_load = 1'b0;
    inst_rdata = {6'h0, 5'd5, 5'd6, 5'd3, 5'd0, 6'h21};
    rf_rdata1 = 32'hAAAA; rf_rdata2 = 32'hBBBB;
    fwd_bus = {ent(1, 5'd6, 32'h66), ent(1, 5'd5, 32'h22), ent(1, 5'd5, 32'h11)};
    tick();
    check("cap_valid", id_valid, 1);
    check("cap_pc", id_pc, 32'h40);
    check("raddr1", rf_raddr1, 5);
    check("fwd_ex_wins", src1, 32'h11);
    check("fwd_src2_wb", src2, 32'h66);
    fwd_bus = {ent(1, 5'd5, 32'h33), ent(1, 5'd5, 32'h22), ent(0, 5'd5, 32'h11)};
    settle();
    check("fwd_mem_wins", src1, 32'h22);
    check("fwd_src2_rf", src2, 32'hBBBB);
    fwd_bus = '0;
    settle();
    check("fwd_none_rf", src1, 32'hAAAA);
    inst_rdata = {6'h0, 5'd0, 5'd6, 5'd3, 5'd0, 6'h21};
    fwd_bus = {ent(0, 0, 0), ent(0, 0, 0), ent(1, 5'd0, 32'h77)};
    settle();
    check("fwd_r0_zero", src1, 0);

    // Load-use: BEQ r8,r9 with EX loading r8
    inst_rdata = {6'b000100, 5'd8, 5'd9, 16'd4};
    fwd_bus = {ent(0, 0, 0), ent(0, 0, 0), ent(1, 5'd8, 32'h5)};
    rf_rdata1 = 32'h1; rf_rdata2 = 32'h5; ex_is_load = 1'b1;
    settle();
    check("lu_stallreq", stallreq, 1);
    check("lu_br_suppr", br_taken, 0);
    check("lu_target0", br_target, 0);
    tick();
    check("lu_stallreq2", stallreq, 1);
    tick();
    ex_is_load = 1'b0;
    settle();
    check("lu_clear", stallreq, 0);
    check("beq_taken", br_taken, 1);
    check("beq_target", br_target, 32'h54);
    tick();
    inst_rdata = {6'h0, 5'd5, 5'd6, 5'd3, 5'd0, 6'h21};
    fwd_bus = '0;
    settle();
`ifdef ID_PERF_CNT_EN
    check("perf_lu", perf_lu_cnt, 2);
    check("perf_br", perf_br_cnt, 1);
`else
    check("perf_lu_off", perf_lu_cnt, 0);
    check("perf_br_off", perf_br_cnt, 0);
`endif

    // Branch targets at pc 0x100
    if_pc = 32'h100;
    tick();
    inst_rdata = {6'b000101, 5'd1, 5'd2, 16'hFFFF};
    rf_rdata1 = 32'h1; rf_rdata2 = 32'h2;
    settle();
    check("bne_taken", br_taken, 1);
    check("bne_target", br_target, 32'h100);
    rf_rdata2 = 32'h1;
    settle();
    check("bne_not", br_taken, 0);
    check("bne_not_tgt", br_target, 0);
    inst_rdata = {6'h0, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08};
    rf_rdata1 = 32'h8000_0040;
    settle();
    check("jr_target", br_target, 32'h8000_0040);
    inst_rdata = {6'b000010, 26'h3FFFFFF};
    settle();
    check("j_target", br_target, 32'h0FFF_FFFC);
    inst_rdata = {6'b000001, 5'd4, 5'd0, 16'h0010};
    rf_rdata1 = 32'hFFFF_FFFF;
    settle();
    check("bltz_target", br_target, 32'h144);
    inst_rdata = {6'b000111, 5'd4, 5'd0, 16'h0010};
    rf_rdata1 = 32'h0;
    settle();
    check("bgtz_zero", br_taken, 0);
    inst_rdata = {6'b000110, 5'd4, 5'd0, 16'h0010};
    settle();
    check("blez_zero", br_target, 32'h144);
    inst_rdata = {6'b000001, 5'd4, 5'd1, 16'h0010};
    settle();
    check("bgez_zero", br_taken, 1);

    // Hold buffer across a 3-cycle ID+EX stall
    if_pc = 32'h200; inst_rdata = 32'hA0A0_0001;
    tick();
    check("hold_pre", id_inst, 32'hA0A0_0001);
    stall_id = 1'b1; stall_ex = 1'b1;
    tick();
    inst_rdata = 32'hB0B0_0002; if_pc = 32'h204;
    settle();
    check("hold_c1", id_inst, 32'hA0A0_0001);
    tick();
    inst_rdata = 32'hC0C0_0003;
    settle();
    check("hold_c2", id_inst, 32'hA0A0_0001);
    tick();
    inst_rdata = 32'hD0D0_0004;
    settle();
    check("hold_c3", id_inst, 32'hA0A0_0001);
    check("hold_pc", id_pc, 32'h200);
    stall_id = 1'b0; stall_ex = 1'b0;
    tick();
    inst_rdata = 32'hE0E0_0005;
    settle();
    check("hold_release", id_inst, 32'hE0E0_0005);
    check("release_pc", id_pc, 32'h204);

    // Bubble, then reset in the middle of a stall
    stall_id = 1'b1;
    tick();
    check("bubble_valid", id_valid, 0);
    check("bubble_inst", id_inst, 0);
    stall_id = 1'b0;
    tick();
    stall_id = 1'b1; stall_ex = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_valid", id_valid, 0);
    check("rst_mid_pc", id_pc, 0);
    rst_n = 1'b1; stall_id = 1'b0; stall_ex = 1'b0; if_pc = 32'h300;
    tick();
    inst_rdata = 32'h1234_5678;
    settle();
    check("post_rst_inst", id_inst, 32'h1234_5678);
    check("post_rst_pc", id_pc, 32'h300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
